// File: rtl/gpio_pkg.sv
// Shared register indices and ID constant for the GPIO MMIO port.
package gpio_pkg;

  typedef enum logic [2:0] {
    GPIO_DIN     = 3'd0,
    GPIO_DOUT    = 3'd1,
    GPIO_DIR     = 3'd2,
    GPIO_RISE_EN = 3'd3,
    GPIO_FALL_EN = 3'd4,
    GPIO_STATUS  = 3'd5,
    GPIO_IEN     = 3'd6,
    GPIO_ID      = 3'd7
  } gpio_reg_e;

  localparam logic [15:0] GPIO_ID_MAGIC = 16'hC0DE;

endpackage

// File: rtl/gpio_mmio_if.sv
// Word-addressed register bus between the core and the GPIO port.
interface gpio_mmio_if;

  logic [2:0]  addr;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output addr,
    output wr_en,
    output rd_en,
    output wdata,
    input  rdata
  );

  modport slave (
    input  addr,
    input  wr_en,
    input  rd_en,
    input  wdata,
    output rdata
  );

endinterface

// File: rtl/gpio_debounce.sv
// One pin: synchroniser chain followed by a persistence counter.
module gpio_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic stable
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // Shift the raw pin through the synchroniser flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  // Accept a synced change only after it has persisted long enough; the counter
  // clears on acceptance so it never runs past CNT_LAST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (synced == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      stable <= synced;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/gpio_mmio_port.sv
// Memory-mapped GPIO: register file, edge capture, W1C status, read mux, irq.
module gpio_mmio_port
  import gpio_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  gpio_mmio_if.slave       bus,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  logic [WIDTH-1:0] din_stable;
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] status;
  logic [WIDTH-1:0] ien;
  logic [WIDTH-1:0] wdata_w;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] w1c_mask;
  logic [31:0]      rd_val;
  gpio_reg_e        sel;

  assign sel     = gpio_reg_e'(bus.addr);
  assign wdata_w = bus.wdata[WIDTH-1:0];

  for (genvar g = 0; g < WIDTH; g++) begin : g_pin
    gpio_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .rst    (rst),
      .din    (gpio_i[g]),
      .stable (din_stable[g])
    );
  end

  // Enabled stable-value transitions and the STATUS clear mask for this cycle.
  always_comb begin
    edge_set = (din_stable & ~stable_q & rise_en) | (~din_stable & stable_q & fall_en);
    w1c_mask = '0;
    if (bus.wr_en && (sel == GPIO_STATUS)) begin
      w1c_mask = wdata_w;
    end
  end

  // Register file; an edge-set overrides a same-cycle W1C clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_q <= '0;
      dout     <= '0;
      dir      <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
      status   <= '0;
      ien      <= '0;
    end else begin
      stable_q <= din_stable;
      status   <= (status & ~w1c_mask) | edge_set;
      if (bus.wr_en) begin
        case (sel)
          GPIO_DOUT:    dout    <= wdata_w;
          GPIO_DIR:     dir     <= wdata_w;
          GPIO_RISE_EN: rise_en <= wdata_w;
          GPIO_FALL_EN: fall_en <= wdata_w;
          GPIO_IEN:     ien     <= wdata_w;
          default:      ;
        endcase
      end
    end
  end

  // Read mux, built from pre-write register values.
  always_comb begin
    rd_val = '0;
    case (sel)
      GPIO_DIN:     rd_val = 32'(din_stable);
      GPIO_DOUT:    rd_val = 32'(dout);
      GPIO_DIR:     rd_val = 32'(dir);
      GPIO_RISE_EN: rd_val = 32'(rise_en);
      GPIO_FALL_EN: rd_val = 32'(fall_en);
      GPIO_STATUS:  rd_val = 32'(status);
      GPIO_IEN:     rd_val = 32'(ien);
      GPIO_ID:      rd_val = {GPIO_ID_MAGIC, 8'(SYNC_STAGES), 8'(WIDTH)};
      default:      rd_val = '0;
    endcase
  end

  // Registered read data, held between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rdata <= '0;
    end else if (bus.rd_en) begin
      bus.rdata <= rd_val;
    end
  end

  assign gpio_o  = dout;
  assign gpio_oe = dir;
  assign irq     = |(status & ien);

endmodule
